// File: rtl/param_rr_arb_mux_pkg.sv
// Shared types and helpers for the round-robin arbiter/mux slice.
package param_rr_arb_mux_pkg;

    typedef enum logic {
        StEmpty,
        StFull
    } arb_state_e;

    // Number of requesters addressed by a select field of the given width.
    function automatic int unsigned num_req(input int unsigned num_slct_lns);
        return 32'd1 << num_slct_lns;
    endfunction

endpackage

// File: rtl/param_mux.sv
// Parameterised N:1 packet multiplexer, N = 2**NUM_SLCT_LNS.
module param_mux
    import param_rr_arb_mux_pkg::*;
#(
    parameter int unsigned NUM_SLCT_LNS = 2,
    parameter int unsigned PCK_SZ       = 4,
    localparam int unsigned N           = num_req(NUM_SLCT_LNS)
) (
    input  logic [NUM_SLCT_LNS-1:0] sel_i,
    input  logic [PCK_SZ-1:0]       data_i [N-1:0],
    output logic [PCK_SZ-1:0]       data_o
);

    assign data_o = data_i[sel_i];

endmodule

// File: rtl/param_rr_arb_mux.sv
// Round-robin arbiter feeding a single-entry output register with valid/ready handshake.
module param_rr_arb_mux
    import param_rr_arb_mux_pkg::*;
#(
    parameter int unsigned NUM_SLCT_LNS = 2,
    parameter int unsigned PCK_SZ       = 4,
    localparam int unsigned N           = num_req(NUM_SLCT_LNS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N-1:0]            i_req_valid,
    input  logic [PCK_SZ-1:0]       i_req_data [N-1:0],
    output logic [N-1:0]            o_req_ready,
    output logic                    o_valid,
    output logic [PCK_SZ-1:0]       o_data,
    output logic [NUM_SLCT_LNS-1:0] o_grant_idx,
    input  logic                    i_ready
);

    arb_state_e              state_q;
    logic [NUM_SLCT_LNS-1:0] rr_ptr_q;
    logic [PCK_SZ-1:0]       data_q;
    logic [NUM_SLCT_LNS-1:0] grant_q;

    logic [NUM_SLCT_LNS-1:0] winner;
    logic                    any_valid;
    logic                    transfer;
    logic [PCK_SZ-1:0]       sel_data;

    // Scan rr_ptr, rr_ptr+1, ... with natural wrap of the select-width sum.
    always_comb begin
        logic [NUM_SLCT_LNS-1:0] idx;
        winner    = rr_ptr_q;
        any_valid = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = rr_ptr_q + NUM_SLCT_LNS'(i);
            if (!any_valid && i_req_valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

    assign transfer = any_valid && ((state_q == StEmpty) || i_ready);

    // Ready is forced low while reset is asserted so nothing is offered asynchronously.
    always_comb begin
        o_req_ready = '0;
        if (i_rst_n && transfer) begin
            o_req_ready[winner] = 1'b1;
        end
    end

    param_mux #(
        .NUM_SLCT_LNS (NUM_SLCT_LNS),
        .PCK_SZ       (PCK_SZ)
    ) u_mux (
        .sel_i  (winner),
        .data_i (i_req_data),
        .data_o (sel_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StEmpty;
            rr_ptr_q <= '0;
            data_q   <= '0;
            grant_q  <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (transfer) begin
                        state_q  <= StFull;
                        data_q   <= sel_data;
                        grant_q  <= winner;
                        rr_ptr_q <= winner + NUM_SLCT_LNS'(1);
                    end
                end
                StFull: begin
                    // Without i_ready the held packet and pointer stay frozen.
                    if (i_ready) begin
                        if (transfer) begin
                            data_q   <= sel_data;
                            grant_q  <= winner;
                            rr_ptr_q <= winner + NUM_SLCT_LNS'(1);
                        end else begin
                            state_q <= StEmpty;
                        end
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    assign o_valid     = (state_q == StFull);
    assign o_data      = data_q;
    assign o_grant_idx = grant_q;

endmodule

// File: tb/tb_param_rr_arb_mux.sv
// Directed self-checking bench for param_rr_arb_mux with N=4, 4-bit packets.
module tb_param_rr_arb_mux;

    localparam int unsigned SL = 2;
    localparam int unsigned PW = 4;
    localparam int unsigned NR = 4;

    logic          clk;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [PW-1:0] req_data [NR-1:0];
    logic [NR-1:0] req_ready;
    logic          out_valid;
    logic [PW-1:0] out_data;
    logic [SL-1:0] grant_idx;
    logic          ready;

    int checks;
    int errors;

    param_rr_arb_mux #(
        .NUM_SLCT_LNS (SL),
        .PCK_SZ       (PW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_grant_idx (grant_idx),
        .i_ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fixed per-requester packets; requester 2 carries 4'hA.
    function automatic logic [PW-1:0] pkt(input int k);
        case (k)
            0:       return 4'h3;
            1:       return 4'h7;
            2:       return 4'hA;
            default: return 4'hC;
        endcase
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        ready  = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) req_data[k] = pkt(k);

        // Asynchronous reset with all inputs active, no clock edge in between.
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_grant", 32'(grant_idx), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_ptr", 32'(dut.rr_ptr_q), 32'd0);
        #1 rst_n = 1'b1;
        #1;
        check("first_ready", 32'(req_ready), 32'b0001);

        // Fairness: all valid, downstream always ready.
        for (int c = 0; c < 8; c++) begin
            step();
            check("fair_valid", 32'(out_valid), 32'd1);
            check("fair_grant", 32'(grant_idx), 32'(c % 4));
            check("fair_data", 32'(out_data), 32'(pkt(c % 4)));
            check("fair_next_ready", 32'(req_ready), 32'(1 << ((c + 1) % 4)));
        end
        check("fair_ptr", 32'(dut.rr_ptr_q), 32'd0);

        // Drain after fairness, then a single transfer and drain again.
        req_valid = 4'b0000;
        #1;
        check("idle_ready", 32'(req_ready), 32'd0);
        step();
        check("drain0_valid", 32'(out_valid), 32'd0);
        req_valid = 4'b0010;
        step();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_grant", 32'(grant_idx), 32'd1);
        check("single_data", 32'(out_data), 32'h7);
        req_valid = 4'b0000;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_ptr", 32'(dut.rr_ptr_q), 32'd2);

        // Backpressure: grant req 2 from EMPTY, then hold with i_ready low.
        req_valid = 4'b1100;
        ready     = 1'b0;
        #1;
        check("bp_empty_ready", 32'(req_ready), 32'b0100);
        step();
        check("bp_grant", 32'(grant_idx), 32'd2);
        check("bp_data", 32'(out_data), 32'hA);
        for (int c = 0; c < 3; c++) begin
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            step();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_grant", 32'(grant_idx), 32'd2);
            check("bp_hold_data", 32'(out_data), 32'hA);
            check("bp_hold_ptr", 32'(dut.rr_ptr_q), 32'd3);
        end
        ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'b1000);
        step();
        check("bp_next_grant", 32'(grant_idx), 32'd3);
        check("bp_next_data", 32'(out_data), 32'hC);

        // Bring rr_ptr to 3, then wrap/skip.
        req_valid = 4'b0100;
        step();
        check("ptr3_grant", 32'(grant_idx), 32'd2);
        check("ptr3_ptr", 32'(dut.rr_ptr_q), 32'd3);
        req_valid = 4'b0010;
        #1;
        check("skip_ready", 32'(req_ready), 32'b0010);
        step();
        check("skip_grant", 32'(grant_idx), 32'd1);
        check("skip_ptr", 32'(dut.rr_ptr_q), 32'd2);
        req_valid = 4'b1000;
        step();
        check("wrap_grant", 32'(grant_idx), 32'd3);
        check("wrap_ptr", 32'(dut.rr_ptr_q), 32'd0);

        // A waiting requester that drops out is skipped; pointer untouched.
        ready     = 1'b0;
        req_valid = 4'b0110;
        step();
        check("drop_hold_grant", 32'(grant_idx), 32'd3);
        req_valid = 4'b0100;
        ready     = 1'b1;
        #1;
        check("drop_ready", 32'(req_ready), 32'b0100);
        check("drop_ptr", 32'(dut.rr_ptr_q), 32'd0);
        step();
        check("drop_grant", 32'(grant_idx), 32'd2);

        // Mid-operation reset while FULL and stalled.
        req_valid = 4'hF;
        ready     = 1'b0;
        step();
        check("mid_full", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_grant", 32'(grant_idx), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        #1 rst_n = 1'b1;
        #1;
        check("mid_rel_ready", 32'(req_ready), 32'b0001);
        step();
        check("mid_first_grant", 32'(grant_idx), 32'd0);
        check("mid_first_data", 32'(out_data), 32'h3);
        check("mid_first_valid", 32'(out_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
